// File: rtl/traffic_pkg.sv
// Shared definitions for the TRAFFIC lamp-bus monitor: phase codes, error codes,
// default plan timing and the legal lamp vectors.
package traffic_pkg;

  localparam int DEF_T_ALLRED = 2;
  localparam int DEF_T_GREEN  = 40;
  localparam int DEF_T_YELLOW = 5;
  localparam int DEF_T_WALK   = 25;
  localparam int DEF_T_FLASH  = 7;
  localparam int DEF_POS_W    = 7;

  typedef enum logic [2:0] {
    PH_ALLRED  = 3'd0,
    PH_R1G     = 3'd1,
    PH_R1Y     = 3'd2,
    PH_R2G     = 3'd3,
    PH_R2Y     = 3'd4,
    PH_WALKG   = 3'd5,
    PH_WALKOFF = 3'd6,
    PH_ILLEGAL = 3'd7
  } phase_t;

  typedef enum logic {
    ST_HUNT  = 1'b0,
    ST_TRACK = 1'b1
  } mon_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SEQ  = 2'd1;
  localparam logic [1:0] ERR_ILL  = 2'd2;
  localparam logic [1:0] ERR_SAFE = 2'd3;

  // Bit order: {R1_G, R1_Y, R1_R, R2_G, R2_Y, R2_R, Walk_G, Walk_R}
  localparam logic [7:0] LAMPS_ALLRED  = 8'b001_001_01;
  localparam logic [7:0] LAMPS_R1G     = 8'b100_001_01;
  localparam logic [7:0] LAMPS_R1Y     = 8'b010_001_01;
  localparam logic [7:0] LAMPS_R2G     = 8'b001_100_01;
  localparam logic [7:0] LAMPS_R2Y     = 8'b001_010_01;
  localparam logic [7:0] LAMPS_WALKG   = 8'b001_001_10;
  localparam logic [7:0] LAMPS_WALKOFF = 8'b001_001_00;

  function automatic phase_t decode_phase(input logic [7:0] lamps);
    phase_t ph;
    case (lamps)
      LAMPS_ALLRED:  ph = PH_ALLRED;
      LAMPS_R1G:     ph = PH_R1G;
      LAMPS_R1Y:     ph = PH_R1Y;
      LAMPS_R2G:     ph = PH_R2G;
      LAMPS_R2Y:     ph = PH_R2Y;
      LAMPS_WALKG:   ph = PH_WALKG;
      LAMPS_WALKOFF: ph = PH_WALKOFF;
      default:       ph = PH_ILLEGAL;
    endcase
    return ph;
  endfunction

  // Two or more of the three right-of-way groups lit at once.
  function automatic logic is_conflict(input logic [7:0] lamps);
    logic r1_go;
    logic r2_go;
    logic walk_go;
    r1_go   = lamps[7] | lamps[6];
    r2_go   = lamps[4] | lamps[3];
    walk_go = lamps[1];
    return (r1_go & r2_go) | (r1_go & walk_go) | (r2_go & walk_go);
  endfunction

endpackage

// File: rtl/traffic_monitor_plan.sv
// tm_plan: combinational map from plan position to the phase TRAFFIC should show.
// Shared between the monitor and the bench scoreboard.
module tm_plan
  import traffic_pkg::*;
#(
  parameter int T_ALLRED = DEF_T_ALLRED,
  parameter int T_GREEN  = DEF_T_GREEN,
  parameter int T_YELLOW = DEF_T_YELLOW,
  parameter int T_WALK   = DEF_T_WALK,
  parameter int T_FLASH  = DEF_T_FLASH,
  parameter int POS_W    = DEF_POS_W
) (
  input  logic [POS_W-1:0] pos,
  output phase_t           expected
);

  // Segment start positions; PERIOD must not exceed 2**POS_W.
  localparam logic [31:0] B_R1G    = 32'(T_ALLRED);
  localparam logic [31:0] B_R1Y    = B_R1G + 32'(T_GREEN);
  localparam logic [31:0] B_AR2    = B_R1Y + 32'(T_YELLOW);
  localparam logic [31:0] B_R2G    = B_AR2 + 32'(T_ALLRED);
  localparam logic [31:0] B_R2Y    = B_R2G + 32'(T_GREEN);
  localparam logic [31:0] B_AR3    = B_R2Y + 32'(T_YELLOW);
  localparam logic [31:0] B_WALK   = B_AR3 + 32'(T_ALLRED);
  localparam logic [31:0] B_FLASH  = B_WALK + 32'(T_WALK);
  localparam logic [31:0] B_END    = B_FLASH + 32'(T_FLASH);
  localparam logic        FLASH_P0 = B_FLASH[0];

  logic [31:0] p;
  assign p = 32'(pos);

  always_comb begin
    expected = PH_ILLEGAL;
    if (p < B_R1G)        expected = PH_ALLRED;
    else if (p < B_R1Y)   expected = PH_R1G;
    else if (p < B_AR2)   expected = PH_R1Y;
    else if (p < B_R2G)   expected = PH_ALLRED;
    else if (p < B_R2Y)   expected = PH_R2G;
    else if (p < B_AR3)   expected = PH_R2Y;
    else if (p < B_WALK)  expected = PH_ALLRED;
    else if (p < B_FLASH) expected = PH_WALKG;
    else if (p < B_END)   // odd offsets into the flash window are dark
      expected = (p[0] ^ FLASH_P0) ? PH_WALKOFF : PH_WALKG;
  end

endmodule

// File: rtl/traffic_monitor.sv
// Passive checker for the TRAFFIC lamp bus: decodes lamp vectors, locks onto the
// signal plan at an ALLRED->R1G edge and reports sequence/encoding/safety faults.
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int T_ALLRED = DEF_T_ALLRED,
  parameter int T_GREEN  = DEF_T_GREEN,
  parameter int T_YELLOW = DEF_T_YELLOW,
  parameter int T_WALK   = DEF_T_WALK,
  parameter int T_FLASH  = DEF_T_FLASH,
  parameter int POS_W    = DEF_POS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       lamps,
  output logic             locked,
  output logic [2:0]       phase,
  output logic [POS_W-1:0] pos,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             safety_fault,
  output logic [15:0]      period_cnt
);

  localparam int PERIOD = 3*T_ALLRED + 2*T_GREEN + 2*T_YELLOW + T_WALK + T_FLASH;
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(PERIOD - 1);
  localparam logic [POS_W-1:0] LOCK_POS = POS_W'(T_ALLRED);

  mon_state_t       state_reg, state_next;
  logic             locked_reg, locked_next;
  phase_t           phase_reg;
  logic [POS_W-1:0] pos_reg, pos_next;
  logic             err_reg, err_next;
  logic [1:0]       err_code_reg, err_code_next;
  logic             safety_reg, safety_next;
  logic [15:0]      period_reg, period_next;
  logic             prev_allred_reg;

  phase_t           cur_phase;
  phase_t           exp_phase;
  logic             conflict;
  logic [POS_W-1:0] exp_pos;
  logic [1:0]       fault_code;

  assign cur_phase = decode_phase(lamps);
  assign conflict  = is_conflict(lamps);
  // Position the incoming vector should occupy if the plan is running.
  assign exp_pos   = (pos_reg == LAST_POS) ? '0 : pos_reg + 1'b1;

  tm_plan #(
    .T_ALLRED (T_ALLRED),
    .T_GREEN  (T_GREEN),
    .T_YELLOW (T_YELLOW),
    .T_WALK   (T_WALK),
    .T_FLASH  (T_FLASH),
    .POS_W    (POS_W)
  ) u_plan (
    .pos      (exp_pos),
    .expected (exp_phase)
  );

  always_comb begin
    fault_code = ERR_NONE;
    if (conflict)
      fault_code = ERR_SAFE;
    else if (cur_phase == PH_ILLEGAL)
      fault_code = ERR_ILL;
    else if (state_reg == ST_TRACK && cur_phase != exp_phase)
      fault_code = ERR_SEQ;
  end

  always_comb begin
    state_next    = state_reg;
    locked_next   = locked_reg;
    pos_next      = pos_reg;
    err_next      = 1'b0;
    err_code_next = err_code_reg;
    safety_next   = safety_reg | conflict;
    period_next   = period_reg;

    if (fault_code != ERR_NONE) begin
      // Any fault drops lock; position stays where the plan was last good.
      err_next      = 1'b1;
      err_code_next = fault_code;
      locked_next   = 1'b0;
      state_next    = ST_HUNT;
    end else begin
      case (state_reg)
        ST_HUNT: begin
          if (prev_allred_reg && cur_phase == PH_R1G) begin
            state_next  = ST_TRACK;
            locked_next = 1'b1;
            pos_next    = LOCK_POS;
          end
        end
        ST_TRACK: begin
          pos_next = exp_pos;
          if (exp_pos == '0 && period_reg != 16'hFFFF)
            period_next = period_reg + 16'd1;
        end
        default: state_next = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_HUNT;
      locked_reg      <= 1'b0;
      phase_reg       <= PH_ALLRED;
      pos_reg         <= '0;
      err_reg         <= 1'b0;
      err_code_reg    <= ERR_NONE;
      safety_reg      <= 1'b0;
      period_reg      <= 16'd0;
      prev_allred_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      locked_reg      <= locked_next;
      phase_reg       <= cur_phase;
      pos_reg         <= pos_next;
      err_reg         <= err_next;
      err_code_reg    <= err_code_next;
      safety_reg      <= safety_next;
      period_reg      <= period_next;
      prev_allred_reg <= (cur_phase == PH_ALLRED);
    end
  end

  assign locked       = locked_reg;
  assign phase        = phase_reg;
  assign pos          = pos_reg;
  assign err          = err_reg;
  assign err_code     = err_code_reg;
  assign safety_fault = safety_reg;
  assign period_cnt   = period_reg;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: decode/plan tables plus multi-cycle
// scenarios driven by a local model of the TRAFFIC lamp sequence.
module tb_traffic_monitor;
  import traffic_pkg::*;

  localparam logic [7:0] L_AR  = 8'b001_001_01;
  localparam logic [7:0] L_R1G = 8'b100_001_01;
  localparam logic [7:0] L_R1Y = 8'b010_001_01;
  localparam logic [7:0] L_R2G = 8'b001_100_01;
  localparam logic [7:0] L_R2Y = 8'b001_010_01;
  localparam logic [7:0] L_WG  = 8'b001_001_10;
  localparam logic [7:0] L_WO  = 8'b001_001_00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  lamps = L_AR;
  logic        locked;
  logic [2:0]  phase;
  logic [6:0]  pos;
  logic        err;
  logic [1:0]  err_code;
  logic        safety_fault;
  logic [15:0] period_cnt;

  logic [6:0]  plan_pos = 7'd0;
  phase_t      plan_exp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .lamps        (lamps),
    .locked       (locked),
    .phase        (phase),
    .pos          (pos),
    .err          (err),
    .err_code     (err_code),
    .safety_fault (safety_fault),
    .period_cnt   (period_cnt)
  );

  tm_plan u_ref (
    .pos      (plan_pos),
    .expected (plan_exp)
  );

  typedef struct {
    logic [7:0] lamps;
    logic [2:0] ph;
    logic       err;
    logic [1:0] code;
    logic       lock;
    logic       saf;
    logic [6:0] pos;
  } vec_t;

  typedef struct {
    logic [6:0] pos;
    logic [2:0] ph;
  } plan_t;

  vec_t  dec_tbl[17];
  plan_t plan_tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Apply one lamp vector for one cycle; outputs reflect it after the edge.
  task automatic cyc(input logic [7:0] v);
    lamps = v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] traffic(input int c);
    if (c < 2)        return L_AR;
    else if (c < 42)  return L_R1G;
    else if (c < 47)  return L_R1Y;
    else if (c < 49)  return L_AR;
    else if (c < 89)  return L_R2G;
    else if (c < 94)  return L_R2Y;
    else if (c < 96)  return L_AR;
    else if (c < 121) return L_WG;
    else if (((c - 121) % 2) == 0) return L_WG;
    else return L_WO;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    lamps = L_AR;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    //                lamps          ph   err  code lock saf  pos
    dec_tbl[0]  = '{L_AR,          3'd0, 1'b0, 2'd0, 1'b0, 1'b0, 7'd0};
    dec_tbl[1]  = '{8'b000_001_01, 3'd7, 1'b1, 2'd2, 1'b0, 1'b0, 7'd0};
    dec_tbl[2]  = '{L_R1Y,         3'd2, 1'b0, 2'd2, 1'b0, 1'b0, 7'd0};
    dec_tbl[3]  = '{L_R1G,         3'd1, 1'b0, 2'd2, 1'b0, 1'b0, 7'd0};
    dec_tbl[4]  = '{L_R2G,         3'd3, 1'b0, 2'd2, 1'b0, 1'b0, 7'd0};
    dec_tbl[5]  = '{L_R2Y,         3'd4, 1'b0, 2'd2, 1'b0, 1'b0, 7'd0};
    dec_tbl[6]  = '{L_WG,          3'd5, 1'b0, 2'd2, 1'b0, 1'b0, 7'd0};
    dec_tbl[7]  = '{L_WO,          3'd6, 1'b0, 2'd2, 1'b0, 1'b0, 7'd0};
    dec_tbl[8]  = '{L_AR,          3'd0, 1'b0, 2'd2, 1'b0, 1'b0, 7'd0};
    dec_tbl[9]  = '{L_WG,          3'd5, 1'b0, 2'd2, 1'b0, 1'b0, 7'd0};
    dec_tbl[10] = '{L_AR,          3'd0, 1'b0, 2'd2, 1'b0, 1'b0, 7'd0};
    dec_tbl[11] = '{L_R2G,         3'd3, 1'b0, 2'd2, 1'b0, 1'b0, 7'd0};
    dec_tbl[12] = '{8'b110_001_01, 3'd7, 1'b1, 2'd2, 1'b0, 1'b0, 7'd0};
    dec_tbl[13] = '{8'b100_100_01, 3'd7, 1'b1, 2'd3, 1'b0, 1'b1, 7'd0};
    dec_tbl[14] = '{L_AR,          3'd0, 1'b0, 2'd3, 1'b0, 1'b1, 7'd0};
    dec_tbl[15] = '{L_R1G,         3'd1, 1'b0, 2'd3, 1'b1, 1'b1, 7'd2};
    dec_tbl[16] = '{8'b001_001_11, 3'd7, 1'b1, 2'd2, 1'b0, 1'b1, 7'd2};

    plan_tbl[0]  = '{7'd0,   3'd0}; plan_tbl[1]  = '{7'd1,   3'd0};
    plan_tbl[2]  = '{7'd2,   3'd1}; plan_tbl[3]  = '{7'd41,  3'd1};
    plan_tbl[4]  = '{7'd42,  3'd2}; plan_tbl[5]  = '{7'd46,  3'd2};
    plan_tbl[6]  = '{7'd47,  3'd0}; plan_tbl[7]  = '{7'd48,  3'd0};
    plan_tbl[8]  = '{7'd49,  3'd3}; plan_tbl[9]  = '{7'd88,  3'd3};
    plan_tbl[10] = '{7'd89,  3'd4}; plan_tbl[11] = '{7'd93,  3'd4};
    plan_tbl[12] = '{7'd94,  3'd0}; plan_tbl[13] = '{7'd95,  3'd0};
    plan_tbl[14] = '{7'd96,  3'd5}; plan_tbl[15] = '{7'd120, 3'd5};
    plan_tbl[16] = '{7'd121, 3'd5}; plan_tbl[17] = '{7'd122, 3'd6};
    plan_tbl[18] = '{7'd123, 3'd5}; plan_tbl[19] = '{7'd126, 3'd6};
    plan_tbl[20] = '{7'd127, 3'd5};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {7'd0, locked, phase, pos, err, err_code, safety_fault, period_cnt},
        32'd0);
    rst = 1'b0;

    for (int k = 0; k < 21; k++) begin
      plan_pos = plan_tbl[k].pos;
      #1;
      chk($sformatf("plan_pos%0d", plan_tbl[k].pos), 32'(plan_exp), 32'(plan_tbl[k].ph));
    end

    for (int k = 0; k < 17; k++) begin
      cyc(dec_tbl[k].lamps);
      $display("vec %0d lamps=%b phase=%0d err=%0b code=%0d locked=%0b saf=%0b pos=%0d",
               k, dec_tbl[k].lamps, phase, err, err_code, locked, safety_fault, pos);
      chk($sformatf("decode_row%0d", k),
          32'({phase, err, err_code, locked, safety_fault, pos}),
          32'({dec_tbl[k].ph, dec_tbl[k].err, dec_tbl[k].code, dec_tbl[k].lock,
               dec_tbl[k].saf, dec_tbl[k].pos}));
    end

    // Real plan from reset: lock at the first R1G, then clean periods
    do_reset();
    for (int i = 0; i < 1066; i++) begin
      cyc(traffic(i % 128));
      chk($sformatf("track_cycle%0d", i), 32'({locked, err, pos, period_cnt}),
          32'({(i >= 2), 1'b0, (i >= 2) ? 7'(i % 128) : 7'd0,
               (i >= 2) ? 16'(i / 128) : 16'd0}));
    end
    $display("plan run done: locked=%0b pos=%0d period_cnt=%0d", locked, pos, period_cnt);

    // R1 green stretched into position 42
    cyc(L_R1G);
    chk("stretch_err", 32'({err, err_code, locked}), 32'({1'b1, 2'd1, 1'b0}));
    chk("stretch_pos_frozen", 32'(pos), 32'd41);
    chk("stretch_period", 32'(period_cnt), 32'd8);
    cyc(L_R1Y);
    chk("stretch_after", 32'({err, err_code, locked}), 32'({1'b0, 2'd1, 1'b0}));
    cyc(L_AR);
    cyc(L_AR);
    cyc(L_R1G);
    chk("relock1", 32'({locked, pos, period_cnt}), 32'({1'b1, 7'd2, 16'd8}));

    // Flash skipped at 121
    for (int c = 3; c <= 120; c++) begin
      cyc(traffic(c));
      chk($sformatf("run_to_flash%0d", c), 32'({locked, err, pos}), 32'({1'b1, 1'b0, 7'(c)}));
    end
    cyc(L_WO);
    chk("flash_skip", 32'({err, err_code, locked, pos}), 32'({1'b1, 2'd1, 1'b0, 7'd120}));
    chk("flash_period", 32'(period_cnt), 32'd8);

    // ALLRED -> R2G must never lock
    cyc(L_AR);
    for (int k = 0; k < 200; k++) begin
      cyc(L_R2G);
      chk("r2g_no_lock", 32'({locked, err}), 32'd0);
    end

    // Illegal-but-no-conflict while locked
    cyc(L_AR);
    cyc(L_R1G);
    chk("relock2", 32'({locked, pos}), 32'({1'b1, 7'd2}));
    cyc(8'b110_001_01);
    chk("ill_locked", 32'({err, err_code, locked, safety_fault}),
        32'({1'b1, 2'd2, 1'b0, 1'b0}));

    // Conflict while locked, then sticky after relock
    cyc(L_AR);
    cyc(L_R1G);
    chk("relock3", 32'(locked), 32'd1);
    cyc(8'b100_100_01);
    chk("conflict", 32'({err, err_code, locked, safety_fault}),
        32'({1'b1, 2'd3, 1'b0, 1'b1}));
    cyc(L_R1Y);
    cyc(L_AR);
    cyc(L_R1G);
    chk("safety_sticky", 32'({locked, err, safety_fault}), 32'({1'b1, 1'b0, 1'b1}));

    // Asynchronous reset mid-period with period_cnt=3
    do_reset();
    for (int i = 0; i <= 444; i++) cyc(traffic(i % 128));
    chk("pre_rst_state", 32'({locked, pos, period_cnt}), 32'({1'b1, 7'd60, 16'd3}));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", {7'd0, locked, phase, pos, err, err_code, safety_fault, period_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(L_AR);
    chk("post_rst_hunt", 32'(locked), 32'd0);
    cyc(L_AR);
    cyc(L_R1G);
    chk("post_rst_relock", 32'({locked, pos, period_cnt, safety_fault}),
        32'({1'b1, 7'd2, 16'd0, 1'b0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
